// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_pkg;

  localparam int unsigned PC_W        = 64;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ALIGN_W     = $clog2(INSTR_BYTES);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // True when the PC points at an instruction boundary.
  function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
    return pc[ALIGN_W-1:0] == ALIGN_W'(0);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: fetches the instruction at CurrentPC over a req/ack
// handshake, holds it for decode, and loads NextPC on each accepted commit.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0,
  parameter int unsigned     INSTR_W  = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [PC_W-1:0]    NextPC,
  input  logic               Commit,
  input  logic               Stall,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic               ImemAck,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [PC_W-1:0]    CurrentPC,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic               Misaligned,
  output logic [31:0]        RetireCount
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         fetch_done;
  logic         commit_ok;

  assign fetch_done = (state_q == REQ) && ImemAck;
  assign commit_ok  = (state_q == EXEC) && Commit && !Stall;

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FAULT is only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (ImemAck) state_d = EXEC;
      end
      EXEC: begin
        if (commit_ok) state_d = pc_aligned(NextPC) ? REQ : FAULT;
      end
      FAULT:   state_d = FAULT;
      default: state_d = REQ;
    endcase
  end

  // Handshake outputs are pure decodes of registered state.
  always_comb begin
    ImemReq    = 1'b0;
    InstrValid = 1'b0;
    case (state_q)
      REQ:     ImemReq    = 1'b1;
      EXEC:    InstrValid = 1'b1;
      default: ;
    endcase
  end

  assign ImemAddr = CurrentPC;

  // PC, instruction latch, retire counter and sticky alignment fault.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CurrentPC   <= RESET_PC;
      Instruction <= INSTR_W'(0);
      RetireCount <= 32'd0;
      Misaligned  <= 1'b0;
    end else begin
      if (fetch_done) begin
        Instruction <= ImemData;
      end
      if (commit_ok) begin
        CurrentPC   <= NextPC;
        RetireCount <= RetireCount + 32'd1;
        if (!pc_aligned(NextPC)) Misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table followed
// by randomized traffic compared against a behavioural model.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] NextPC;
  logic        Commit;
  logic        Stall;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [63:0] CurrentPC;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Misaligned;
  logic [31:0] RetireCount;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer #(.RESET_PC(64'h0), .INSTR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Commit(Commit), .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .CurrentPC(CurrentPC), .Instruction(Instruction), .InstrValid(InstrValid),
    .Misaligned(Misaligned), .RetireCount(RetireCount)
  );

  typedef struct {
    logic        rst;
    logic        commit;
    logic        stall;
    logic        ack;
    logic [63:0] npc;
    logic [31:0] data;
    logic        e_req;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic commit, input logic stall,
                              input logic ack, input logic [63:0] npc, input logic [31:0] data,
                              input logic e_req, input logic e_valid, input logic [63:0] e_pc,
                              input logic [31:0] e_instr, input logic e_mis, input logic [31:0] e_ret);
    vec_t v;
    v.rst = rst; v.commit = commit; v.stall = stall; v.ack = ack; v.npc = npc; v.data = data;
    v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_mis = e_mis; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_req, input logic e_valid,
                           input logic [63:0] e_pc, input logic [31:0] e_instr,
                           input logic e_mis, input logic [31:0] e_ret);
    check("ImemReq", 64'(ImemReq), 64'(e_req), idx);
    check("InstrValid", 64'(InstrValid), 64'(e_valid), idx);
    check("CurrentPC", CurrentPC, e_pc, idx);
    check("ImemAddr", ImemAddr, e_pc, idx);
    check("Instruction", 64'(Instruction), 64'(e_instr), idx);
    check("Misaligned", 64'(Misaligned), 64'(e_mis), idx);
    check("RetireCount", 64'(RetireCount), 64'(e_ret), idx);
  endtask

  // Apply inputs, clock once, then sample just after the edge.
  task automatic step(input logic rst, input logic commit, input logic stall,
                      input logic ack, input logic [63:0] npc, input logic [31:0] data);
    Reset = rst; Commit = commit; Stall = stall; ImemAck = ack; NextPC = npc; ImemData = data;
    @(posedge CLK);
    #1;
  endtask

  // Behavioural reference: what the sequencer is doing, not how it encodes it.
  logic        m_waiting_fetch;
  logic        m_dead;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;
  logic [31:0] m_ret;

  task automatic model_reset();
    m_waiting_fetch = 1'b1; m_dead = 1'b0;
    m_pc = 64'h0; m_instr = 32'h0; m_mis = 1'b0; m_ret = 32'h0;
  endtask

  task automatic model_step(input logic rst, input logic commit, input logic stall,
                            input logic ack, input logic [63:0] npc, input logic [31:0] data);
    if (rst) begin
      model_reset();
    end else if (m_dead) begin
      // faulted: nothing moves
    end else if (m_waiting_fetch) begin
      if (ack) begin
        m_instr = data;
        m_waiting_fetch = 1'b0;
      end
    end else if (commit && !stall) begin
      m_pc  = npc;
      m_ret = m_ret + 1;
      if ((npc % 4) != 0) begin
        m_mis  = 1'b1;
        m_dead = 1'b1;
      end else begin
        m_waiting_fetch = 1'b1;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Commit = 1'b0; Stall = 1'b0; ImemAck = 1'b0;
    NextPC = 64'h0; ImemData = 32'h0;

    //            rst commit stall ack npc     data          req val pc      instr         mis ret
    vecs.push_back(mk(1, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h0,  32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'h0,   32'h8B020020, 0, 1, 64'h0,  32'h8B020020, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 64'h4,   32'h0,        0, 1, 64'h0,  32'h8B020020, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 64'h4,   32'h0,        0, 1, 64'h0,  32'h8B020020, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'h4,   32'h0,        1, 0, 64'h4,  32'h8B020020, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h4,  32'h8B020020, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'h100, 32'h0,        1, 0, 64'h4,  32'h8B020020, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 64'h0,   32'h11111111, 0, 1, 64'h4,  32'h11111111, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 64'h0,   32'h22222222, 0, 1, 64'h4,  32'h11111111, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'h40,  32'h0,        1, 0, 64'h40, 32'h11111111, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h40, 32'h11111111, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h40, 32'h11111111, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h40, 32'h11111111, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 64'h0,   32'h33333333, 0, 1, 64'h40, 32'h33333333, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 64'h42,  32'h0,        0, 0, 64'h42, 32'h33333333, 1, 3));
    vecs.push_back(mk(0, 1, 0, 1, 64'h8,   32'h55555555, 0, 0, 64'h42, 32'h33333333, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 64'h8,   32'h66666666, 0, 0, 64'h42, 32'h33333333, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h0,  32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,   32'h0,        1, 0, 64'h0,  32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0,   32'h44444444, 1, 0, 64'h0,  32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].commit, vecs[i].stall, vecs[i].ack, vecs[i].npc, vecs[i].data);
      check_all(i, vecs[i].e_req, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                vecs[i].e_mis, vecs[i].e_ret);
    end

    // Peak throughput: ack on first REQ cycle, commit on first EXEC cycle.
    step(0, 0, 0, 1, 64'h0, 32'hAAAA0001);
    check_all(100, 0, 1, 64'h0, 32'hAAAA0001, 0, 0);
    step(0, 1, 0, 0, 64'h4, 32'h0);
    check_all(101, 1, 0, 64'h4, 32'hAAAA0001, 0, 1);
    step(0, 0, 0, 1, 64'h0, 32'hAAAA0002);
    check_all(102, 0, 1, 64'h4, 32'hAAAA0002, 0, 1);
    step(0, 1, 0, 0, 64'h8, 32'h0);
    check_all(103, 1, 0, 64'h8, 32'hAAAA0002, 0, 2);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 64'h0, 32'h0);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_commit, r_stall, r_ack;
      logic [63:0] r_npc;
      logic [31:0] r_data;
      r_rst    = ($urandom_range(0, 99) == 0);
      r_commit = ($urandom_range(0, 2) != 0);
      r_stall  = ($urandom_range(0, 3) == 0);
      r_ack    = ($urandom_range(0, 1) == 1);
      r_npc    = {$urandom(), $urandom()};
      if ($urandom_range(0, 24) != 0) r_npc[1:0] = 2'b00;
      r_data   = $urandom();
      step(r_rst, r_commit, r_stall, r_ack, r_npc, r_data);
      model_step(r_rst, r_commit, r_stall, r_ack, r_npc, r_data);
      check_all(1000 + n, m_waiting_fetch && !m_dead, !m_waiting_fetch && !m_dead,
                m_pc, m_instr, m_mis, m_ret);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Sequential owner of the program counter and consumer of the next-PC value produced by the branch/next-PC logic. Holds `CurrentPC`, fetches the instruction at that address from instruction memory over a req/ack handshake, presents it to decode, and loads the supplied `NextPC` when the datapath commits the instruction. Sits between instruction memory and the decode/execute datapath, closing the PC loop that the combinational next-PC logic only computes.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset; must be 4-byte aligned.
- `INSTR_W`, 32, instruction width in bits.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `NextPC`  in  64  next-PC value from the next-PC logic; sampled only on an accepted commit.
- `Commit`  in  1  datapath has finished the current instruction; `NextPC` is valid.
- `Stall`  in  1  holds the current instruction; blocks commit.
- `ImemReq`  out  1  fetch request; high only in state REQ.
- `ImemAddr`  out  64  fetch address; always equals `CurrentPC`.
- `ImemAck`  in  1  memory returns data this cycle; honoured only while `ImemReq`=1.
- `ImemData`  in  INSTR_W  instruction word, valid with `ImemAck`.
- `CurrentPC`  out  64  address of the instruction being fetched or executed.
- `Instruction`  out  INSTR_W  latched instruction word.
- `InstrValid`  out  1  `Instruction` is valid for decode; high only in state EXEC.
- `Misaligned`  out  1  sticky fault: a committed `NextPC` had nonzero bits [1:0].
- `RetireCount`  out  32  number of accepted commits; wraps modulo 2^32.

## Operation
- States: REQ, EXEC, FAULT.
- REQ: `ImemReq`=1, `ImemAddr`=`CurrentPC`. On `ImemAck`=1: `Instruction` <= `ImemData`, go to EXEC. Otherwise stay; request is held high, with address stable, until acked.
- EXEC: `InstrValid`=1. Accepted commit = `Commit` & ~`Stall`. On an accepted commit: `CurrentPC` <= `NextPC`, `RetireCount` += 1. Then go to REQ if `NextPC[1:0]`==0; otherwise go to FAULT and set `Misaligned`.
- FAULT: `ImemReq`=0 and `InstrValid`=0. `CurrentPC` holds the faulting value. Only `Reset` exits.
- `Commit` outside EXEC is ignored, with no state or counter change.
- `ImemAck` outside REQ is ignored; `Instruction` is not overwritten.
- `Stall`=1 with `Commit`=1 in EXEC: the stall wins; nothing changes and the commit must be re-presented.
- `Stall` has no effect in REQ; the fetch proceeds.
- No arithmetic on the PC inside this block. The PC+4 or branch target comes entirely from `NextPC`.

## Timing
- Reset values: `CurrentPC`=`RESET_PC`, `Instruction`=0, `RetireCount`=0, `Misaligned`=0, state=REQ. As a result, `ImemReq`=1 in the first cycle after reset.
- `Reset` asserted in any state, including mid-handshake or in FAULT, overrides everything at the next edge. A pending ack in that cycle is dropped.
- `ImemReq`, `ImemAddr` and `InstrValid` are decoded from registered state/PC, with no combinational path from inputs.
- Fetch latency: an ack in cycle N gives `InstrValid`=1 in cycle N+1.
- Commit latency: an accepted commit in cycle M gives the new `CurrentPC`/`ImemAddr` and `ImemReq`=1 in cycle M+1.
- Peak throughput: one instruction per 2 cycles, with ack on the first REQ cycle and commit on the first EXEC cycle.

## Structure
- Shared package `pc_fetch_pkg`: state enum {REQ, EXEC, FAULT}, `INSTR_BYTES`=4, `PC_W`=64.
- Flat module; no sub-module is warranted. The retire counter and the FSM are inline.

## Test plan
- Reset then immediate ack with `ImemData`=32'h8B020020 → next cycle `InstrValid`=1, `Instruction`=32'h8B020020, `CurrentPC`=0.
- Ack delayed 3 cycles → `ImemReq` held high and `ImemAddr` stable at 0 for all 4 cycles. An ack injected in EXEC beforehand leaves `Instruction` unchanged.
- In EXEC, `NextPC`=64'h4 with `Commit`=1, `Stall`=1 for 2 cycles, then `Stall`=0 → `CurrentPC` changes only after the stall drops. Then `CurrentPC`=4, `RetireCount`=1, `ImemReq`=1.
- Branch: commit `NextPC`=64'h40 → `ImemAddr`=64'h40 next cycle. Loop 2^32 commits (or force the counter to 32'hFFFFFFFF) → `RetireCount` wraps to 0.
- Commit `NextPC`=64'h42 → FAULT: `Misaligned`=1, `CurrentPC`=64'h42, `ImemReq`=0. Further commit and ack pulses are ignored.
- `Reset` pulsed while in REQ awaiting ack and again in FAULT → all outputs return to reset values, and `ImemReq`=1 at address `RESET_PC`.
